// File: rtl/pwm_meas.sv
// Servo-PWM receiver: measures active-pulse width in prescaler ticks and maps 1.0..2.0 ms to duty 0..100.
// Optional glitch filter on the synchronised input is enabled by defining PWM_MEAS_FILTER_EN.
module pwm_meas #(
    parameter int PRESCALER_MAX = 119,
    parameter int MIN_W         = 50,
    parameter int MAX_W         = 250,
    parameter int TIMEOUT_TICKS = 2500
`ifdef PWM_MEAS_FILTER_EN
    ,
    parameter int FILT_LEN      = 4
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    input  logic       invert_polarity,
    output logic [6:0] dc_out,
    output logic       dc_valid,
    output logic       dc_strobe,
    output logic       pulse_err,
    output logic       sig_lost
);

    localparam int              PW        = (PRESCALER_MAX > 0) ? $clog2(PRESCALER_MAX + 1) : 1;
    localparam logic [PW-1:0]   PRESC_TOP = PW'(PRESCALER_MAX);
    localparam logic [8:0]      W_MIN     = 9'(MIN_W);
    localparam logic [8:0]      W_MAX     = 9'(MAX_W);
    localparam logic [8:0]      W_SAT     = 9'(MAX_W + 1);
    localparam logic [11:0]     T_FULL    = 12'(TIMEOUT_TICKS);
    localparam logic [11:0]     T_LAST    = 12'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t         state;
    logic           sync_q1;
    logic           sync_q2;
    logic           lvl_raw;
    logic           lvl;
    logic           lvl_d;
    logic           rise;
    logic           fall;
    logic           tick;
    logic           timeout;
    logic [PW-1:0]  presc;
    logic [8:0]     width_cnt;
    logic [11:0]    per_cnt;
    logic           arm_low;
    logic           eval_pend;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
        end
    end

    assign lvl_raw = sync_q2 ^ invert_polarity;

`ifdef PWM_MEAS_FILTER_EN
    localparam int            FW       = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FILT_TOP = FW'(FILT_LEN - 1);

    logic           lvl_f;
    logic [FW-1:0]  filt_cnt;

    // lvl follows lvl_raw only after FILT_LEN consecutive clocks at the new value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_f    <= 1'b0;
            filt_cnt <= '0;
        end else if (lvl_raw == lvl_f) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_TOP) begin
            lvl_f    <= lvl_raw;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign lvl = lvl_f;
`else
    assign lvl = lvl_raw;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) lvl_d <= 1'b0;
        else        lvl_d <= lvl;
    end

    assign rise    = lvl & ~lvl_d;
    assign fall    = ~lvl & lvl_d;
    assign tick    = (presc == PRESC_TOP);
    // Fires once, on the tick that brings per_cnt to TIMEOUT_TICKS.
    assign timeout = tick && (per_cnt == T_LAST) && !rise;

    function automatic logic [6:0] duty_of(input logic [8:0] w);
        if (w < 9'd100)      return 7'd0;
        else if (w > 9'd200) return 7'd100;
        else                 return 7'(w - 9'd100);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARM;
            presc     <= '0;
            width_cnt <= '0;
            per_cnt   <= '0;
            arm_low   <= 1'b0;
            eval_pend <= 1'b0;
            dc_out    <= '0;
            dc_valid  <= 1'b0;
            dc_strobe <= 1'b0;
            pulse_err <= 1'b0;
            sig_lost  <= 1'b0;
        end else begin
            dc_strobe <= 1'b0;
            pulse_err <= 1'b0;
            eval_pend <= 1'b0;

            presc <= (rise || tick) ? '0 : presc + 1'b1;

            if (rise)                         per_cnt <= '0;
            else if (tick && per_cnt != T_FULL) per_cnt <= per_cnt + 1'b1;

            // The tick coinciding with the falling edge still counts, giving floor(high_clks/tick).
            if (rise)
                width_cnt <= '0;
            else if (state == HIGH && tick && width_cnt != W_SAT)
                width_cnt <= width_cnt + 1'b1;

            // ARM leaves only after lvl has stayed low across a full tick, so a
            // pulse already in progress at reset or after a reject is never measured.
            if (lvl)       arm_low <= 1'b0;
            else if (tick) arm_low <= 1'b1;

            if (timeout) begin
                sig_lost <= 1'b1;
                dc_valid <= 1'b0;
                state    <= ARM;
            end else begin
                if (eval_pend) begin
                    if (width_cnt < W_MIN || width_cnt > W_MAX) begin
                        pulse_err <= 1'b1;
                    end else begin
                        dc_out    <= duty_of(width_cnt);
                        dc_strobe <= 1'b1;
                        dc_valid  <= 1'b1;
                        sig_lost  <= 1'b0;
                    end
                end

                case (state)
                    ARM: begin
                        if (tick && arm_low && !lvl) state <= LOW;
                    end
                    LOW: begin
                        if (rise) state <= HIGH;
                    end
                    HIGH: begin
                        if (fall) begin
                            eval_pend <= 1'b1;
                            state     <= LOW;
                        end else if (width_cnt == W_SAT) begin
                            pulse_err <= 1'b1;
                            state     <= ARM;
                        end
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas with a shortened prescaler (4 clk per tick) so whole
// 20 ms frames and the 25 ms timeout fit in a short run; pulse widths stay in ticks.
module tb_pwm_meas;

    localparam int PMAX = 3;
    localparam int TICK = PMAX + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_in = 1'b0;
    logic       invert_polarity = 1'b0;
    logic [6:0] dc_out;
    logic       dc_valid;
    logic       dc_strobe;
    logic       pulse_err;
    logic       sig_lost;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_strobe = 0;
    int n_err = 0;
    int n_both = 0;
    int last_err_cyc = 0;

    always #5 clk = ~clk;

    pwm_meas #(.PRESCALER_MAX(PMAX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pwm_in         (pwm_in),
        .invert_polarity(invert_polarity),
        .dc_out         (dc_out),
        .dc_valid       (dc_valid),
        .dc_strobe      (dc_strobe),
        .pulse_err      (pulse_err),
        .sig_lost       (sig_lost)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dc_strobe) n_strobe++;
        if (pulse_err) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (dc_strobe && pulse_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_pulse(input int hi_ticks, input int lo_ticks);
        pwm_in = ~invert_polarity;
        wait_clk(hi_ticks * TICK);
        pwm_in = invert_polarity;
        wait_clk(lo_ticks * TICK);
    endtask

    task automatic measure(input int hi_ticks, input int lo_ticks, input int exp_dc, input string tag);
        int s0;
        int e0;
        s0 = n_strobe;
        e0 = n_err;
        drive_pulse(hi_ticks, lo_ticks);
        check({tag, "_dc_out"}, dc_out, exp_dc);
        check({tag, "_strobes"}, n_strobe - s0, 1);
        check({tag, "_errs"}, n_err - e0, 0);
        check({tag, "_valid"}, dc_valid, 1);
        check({tag, "_lost"}, sig_lost, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int e0;
        int rise_cyc;

        // Reset values
        rst_n = 1'b0;
        wait_clk(3);
        check("rst_dc_out", dc_out, 0);
        check("rst_valid", dc_valid, 0);
        check("rst_lost", sig_lost, 0);
        check("rst_strobe", dc_strobe, 0);
        check("rst_err", pulse_err, 0);
        rst_n = 1'b1;

        // Idle low: sig_lost at 2500 ticks (10000 clk) after reset release
        wait_clk(9900);
        check("idle_lost_early", sig_lost, 0);
        wait_clk(200);
        check("idle_lost_late", sig_lost, 1);
        check("idle_valid", dc_valid, 0);
        check("idle_strobes", n_strobe, 0);
        wait_clk(2000);
        check("idle_lost_30ms", sig_lost, 1);

        // Nominal 20 ms frames
        measure(100, 1900, 0, "f1p0");
        measure(150, 1850, 50, "f1p5");
        measure(200, 1800, 100, "f2p0");

        // Clamp regions
        measure(80, 300, 0, "w0p8");
        measure(230, 300, 100, "w2p3");

        // Too short: reject, output unchanged
        s0 = n_strobe;
        e0 = n_err;
        drive_pulse(30, 300);
        check("short_errs", n_err - e0, 1);
        check("short_strobes", n_strobe - s0, 0);
        check("short_dc_out", dc_out, 100);
        check("short_valid", dc_valid, 1);

        // Too long: reject when width reaches MAX_W+1, before the falling edge
        s0 = n_strobe;
        e0 = n_err;
        rise_cyc = cyc;
        drive_pulse(300, 300);
        check("long_errs", n_err - e0, 1);
`ifdef PWM_MEAS_FILTER_EN
        check("long_err_delay", last_err_cyc - rise_cyc, 1012);
`else
        check("long_err_delay", last_err_cyc - rise_cyc, 1008);
`endif
        check("long_strobes", n_strobe - s0, 0);
        check("long_dc_out", dc_out, 100);

        // Reset in the middle of a 1.2 ms pulse
        s0 = n_strobe;
        e0 = n_err;
        pwm_in = 1'b1;
        wait_clk(60 * TICK);
        rst_n = 1'b0;
        wait_clk(1);
        check("midrst_dc_out", dc_out, 0);
        check("midrst_valid", dc_valid, 0);
        check("midrst_lost", sig_lost, 0);
        rst_n = 1'b1;
        wait_clk(60 * TICK - 1);
        pwm_in = 1'b0;
        wait_clk(300 * TICK);
        check("midrst_strobes", n_strobe - s0, 0);
        check("midrst_errs", n_err - e0, 0);
        check("midrst_dc_hold", dc_out, 0);
        measure(170, 300, 70, "after_rst_1p7");

        // Inverted polarity: active-low 1.5 ms pulse
        invert_polarity = 1'b1;
        pwm_in = 1'b1;
        wait_clk(10);
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(50 * TICK);
        measure(150, 300, 50, "inv1p5");

        // 2-clk glitch during the low phase
        invert_polarity = 1'b0;
        pwm_in = 1'b0;
        wait_clk(10);
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(50 * TICK);
        s0 = n_strobe;
        e0 = n_err;
        pwm_in = 1'b1;
        wait_clk(2);
        pwm_in = 1'b0;
        wait_clk(100 * TICK);
`ifdef PWM_MEAS_FILTER_EN
        check("glitch_errs", n_err - e0, 0);
`else
        check("glitch_errs", n_err - e0, 1);
`endif
        check("glitch_strobes", n_strobe - s0, 0);
        check("glitch_dc_out", dc_out, 0);

        check("strobe_err_exclusive", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
